// File: rtl/ks_seq_pkg.sv
// Shared types and constants for the nibble-serial Kogge-Stone add sequencer.
package ks_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ks_adder4.sv
// Combinational 4-bit Kogge-Stone adder slice with carry in/out.
module ks_adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g, p, gg, g1, p1, g2;

   // Carry-in is folded into bit 0's generate so the prefix tree sees it.
   always_comb begin
      g     = a & b;
      p     = a ^ b;
      gg    = {g[3:1], g[0] | (p[0] & cin)};

      g1[0] = gg[0];
      p1[0] = p[0];
      for (int i = 1; i < 4; i++) begin
         g1[i] = gg[i] | (p[i] & gg[i-1]);
         p1[i] = p[i] & p[i-1];
      end

      g2[1:0] = g1[1:0];
      for (int i = 2; i < 4; i++) begin
         g2[i] = g1[i] | (p1[i] & g1[i-2]);
      end

      sum  = p ^ {g2[2:0], cin};
      cout = g2[3];
   end

endmodule

// File: rtl/ks_add_sequencer.sv
// Two-requester round-robin add sequencer, one 4-bit Kogge-Stone pass per cycle.
// Optional subtract mode (b inverted, carry-in 1) when KS_SEQ_SUB_EN is defined.
module ks_add_sequencer
   import ks_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
`ifdef KS_SEQ_SUB_EN
   input  logic             req0_sub,
   input  logic             req1_sub,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
   output logic             busy,
   output state_t           state_dbg
);

   localparam int NIB = WIDTH / NIB_W;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. req*_ready is a one-cycle grant pulse from IDLE only; res_valid
   // holds with stable data until res_ready is seen.

   state_t           state;
   logic             ptr;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] a_q, b_q;
   logic             grant0, grant1;
   logic [3:0]       nib_a, nib_b, nib_s;
   logic             nib_c;
`ifdef KS_SEQ_SUB_EN
   logic             sub_q;
`endif

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst && state == IDLE) begin
         if (req0_valid && (!req1_valid || !ptr))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state != IDLE);
   assign state_dbg  = state;

   always_comb begin
      nib_a = a_q[idx*NIB_W +: NIB_W];
`ifdef KS_SEQ_SUB_EN
      nib_b = b_q[idx*NIB_W +: NIB_W] ^ {NIB_W{sub_q}};
`else
      nib_b = b_q[idx*NIB_W +: NIB_W];
`endif
   end

   ks_adder4 u_adder4 (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .sum  (nib_s),
      .cout (nib_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= 1'b0;
         res_valid <= 1'b0;
`ifdef KS_SEQ_SUB_EN
         sub_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  a_q      <= grant1 ? req1_a : req0_a;
                  b_q      <= grant1 ? req1_b : req0_b;
                  res_id   <= grant1;
                  ptr      <= grant0;
                  idx      <= '0;
                  res_sum  <= '0;
                  res_cout <= 1'b0;
`ifdef KS_SEQ_SUB_EN
                  sub_q    <= grant1 ? req1_sub : req0_sub;
                  carry    <= grant1 ? req1_sub : req0_sub;
`else
                  carry    <= 1'b0;
`endif
                  state    <= ADD;
               end
            end
            ADD: begin
               res_sum[idx*NIB_W +: NIB_W] <= nib_s;
               carry <= nib_c;
               if (idx == IW'(NIB - 1)) begin
                  idx       <= '0;
                  res_cout  <= nib_c;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ks_add_sequencer.sv
// Scoreboard bench for ks_add_sequencer: arbitration, latency, backpressure, reset abort.
module tb_ks_add_sequencer;
   import ks_seq_pkg::*;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic             req0_sub = 1'b0, req1_sub = 1'b0;
   logic             res_valid, res_ready = 1'b1;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout, res_id, busy;
   state_t           state_dbg;

   always #5 clk = ~clk;

   ks_add_sequencer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
`ifdef KS_SEQ_SUB_EN
      .req0_sub   (req0_sub),
      .req1_sub   (req1_sub),
`endif
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [WIDTH+1:0] exp_q[$];
   logic [WIDTH+1:0] mon_e;
   int               cyc = 0;
   int               acc_cyc = 0;
   logic             rv_prev = 1'b0, rdy_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // Expected {id, cout, sum} from plain wide arithmetic.
   function automatic logic [WIDTH+1:0] model(input logic id, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic sub);
      logic [WIDTH:0] s;
      if (sub) s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      else     s = {1'b0, a} + {1'b0, b};
      return {id, s};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: push on accept, pop and compare on result transfer.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         rv_prev  = 1'b0;
         rdy_prev = 1'b0;
      end else begin
         if (req0_ready || req1_ready) begin
            check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
            check("ready_pulse", 32'(rdy_prev), 32'd0);
            if (req0_ready) exp_q.push_back(model(1'b0, req0_a, req0_b, req0_sub));
            else            exp_q.push_back(model(1'b1, req1_a, req1_b, req1_sub));
            acc_cyc = cyc;
         end
         if (res_valid && !rv_prev)
            check("latency", 32'(cyc - acc_cyc), 32'(NIB + 1));
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("result", 32'({res_id, res_cout, res_sum}), 32'(mon_e));
            end
         end
         rv_prev  = res_valid;
         rdy_prev = req0_ready | req1_ready;
      end
   end

   // All driver tasks start and end at a falling edge.
   task automatic wait_grant(output int id);
      id = -1;
      for (int k = 0; k < 60; k++) begin
         if (req0_ready) begin id = 0; break; end
         if (req1_ready) begin id = 1; break; end
         @(negedge clk);
      end
      if (id < 0) check("grant_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 200; k++) begin
         if (exp_q.size() == 0 && !busy) break;
         @(negedge clk);
      end
      if (k == 200) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic issue(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub);
      int g;
      @(posedge clk); #1;
      if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
      else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
      @(negedge clk);
      wait_grant(g);
      check("grant_id", 32'(g), 32'(id));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
   endtask

   // Both requesters held valid; grants must alternate starting with req0.
   task automatic run_both(input int n);
      int id;
      for (int g = 0; g < n; g++) begin
         wait_grant(id);
         check("grant_order", 32'(id), 32'(g % 2));
         @(posedge clk); #1;
         if (id == 0) begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
         else         begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
         if (g == n - 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         @(negedge clk);
      end
      wait_drain();
   endtask

   logic [WIDTH+1:0] exp_bp;

   initial begin
      // Reset with both requesters already pending.
      req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
      req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444;
      @(negedge clk);
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(res_sum), 32'd0);
      check("rst_cout", 32'(res_cout), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      run_both(3);

      issue(0, 16'h1234, 16'h0FCD, 1'b0);
      wait_drain();
      issue(1, 16'hFFFF, 16'h0001, 1'b0);
      wait_drain();

      // Backpressure in DONE with a competing request pending.
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      issue(0, 16'h00FF, 16'h0101, 1'b0);
      exp_bp = model(1'b0, 16'h00FF, 16'h0101, 1'b0);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0002;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         if (res_valid) break;
         @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
         if (j > 0) @(negedge clk);
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_result", 32'({res_id, res_cout, res_sum}), 32'(exp_bp));
         check("bp_ready0", 32'(req0_ready), 32'd0);
         check("bp_ready1", 32'(req1_ready), 32'd0);
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      check("bp_no_accept_in_done", 32'(req1_ready), 32'd0);
      @(negedge clk);
      check("bp_idle_busy", 32'(busy), 32'd0);
      check("bp_idle_state", 32'(state_dbg), 32'(IDLE));
      check("bp_next_accept", 32'(req1_ready), 32'd1);
      @(posedge clk); #1 req1_valid = 1'b0;
      @(negedge clk);
      wait_drain();

      // Reset pulsed during the second ADD cycle aborts the operation.
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 16'hABCD; req1_b = 16'h1357;
      @(negedge clk);
      begin
         int g;
         wait_grant(g);
         check("abort_grant", 32'(g), 32'd1);
      end
      @(posedge clk); #1 req1_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_res_valid", 32'(res_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_state", 32'(state_dbg), 32'(IDLE));
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 16'h8000; req0_b = 16'h8000;
      req1_valid = 1'b1; req1_a = 16'hABCD; req1_b = 16'h1357;
      @(negedge clk);
      run_both(2);

      // Random operations with random result backpressure.
      for (int n = 0; n < 20; n++) begin
         issue(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
         for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk); #1 res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         @(posedge clk); #1 res_ready = 1'b1;
         @(negedge clk);
         wait_drain();
      end

`ifdef KS_SEQ_SUB_EN
      issue(0, 16'h0005, 16'h0007, 1'b1);
      wait_drain();
      issue(1, 16'h0007, 16'h0005, 1'b1);
      wait_drain();
      for (int n = 0; n < 8; n++) begin
         issue(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         wait_drain();
      end
`endif

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ks_add_sequencer.md
KS_ADD_SEQUENCER -- requirements
Module: ks_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant NIB = WIDTH/4, the number of nibble passes per operation.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0_valid / req1_valid  in  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  out  1  operation of requester n accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands per requester.
REQ-008 res_valid  out  1 / res_ready  in  1  result handshake.
REQ-009 res_sum  out  WIDTH  result; res_cout  out  1  carry out of the MSB nibble; res_id  out  1  index of the served requester.
REQ-010 busy  out  1  high in any state other than IDLE.

Function
REQ-011 FSM states: IDLE, ADD, DONE; reset state is IDLE.
REQ-012 IDLE: if any req valid, grant exactly one, latch its a/b/id, assert its ready for that cycle only, go to ADD; otherwise stay in IDLE.
REQ-013 Arbitration: round-robin; when only one request is valid, it is granted; when both are valid, the requester named by the priority pointer is granted; after each grant the pointer points to the other requester.
REQ-014 req*_ready SHALL be low in ADD and DONE; it is a combinational function of state, valid and pointer.
REQ-015 ADD: nibble index i runs 0..NIB-1, one per cycle; each cycle one 4-bit slice adds nibble i of a and b with the carry register, writes sum nibble i and updates the carry register.
REQ-016 Carry-in at i=0 is 0 (add); after i=NIB-1 the carry register holds res_cout; go to DONE.
REQ-017 Latency: accept in cycle T; res_valid high from cycle T+NIB+1.
REQ-018 DONE: res_valid high; res_sum, res_cout and res_id stable until res_ready is sampled high, then return to IDLE; no new accept occurs in that same cycle.
REQ-019 Arithmetic wraps modulo 2^WIDTH; overflow is reported only through res_cout.
REQ-020 A request that stays valid while not granted SHALL be served later without loss; operands are sampled only in the accept cycle.

Reset
REQ-021 On rst: state=IDLE, pointer=req0, nibble index=0, carry=0, res_sum=0, res_cout=0, res_id=0, res_valid=0, busy=0, req*_ready=0.
REQ-022 Reset mid-ADD or mid-DONE SHALL abort the operation, discard the result, and leave no residue; the requester re-presents its request.

Configuration
REQ-023 Macro KS_SEQ_SUB_EN: when defined, ports req0_sub and req1_sub (in, 1) exist and are latched at accept; sub=1 inverts b and forces carry-in 1 at i=0, giving a-b, with res_cout=1 meaning no borrow.
REQ-024 Without KS_SEQ_SUB_EN: these ports and the related logic are absent; the block only adds.

Structure
REQ-025 Shared package ks_seq_pkg SHALL hold the state enum typedef and the nibble-width constant (4).
REQ-026 Sub-module ks_adder4: combinational 4-bit Kogge-Stone slice (a, b, cin -> sum, cout); ks_add_sequencer instantiates exactly one.

Verification (WIDTH=16, NIB=4)
REQ-027 req0 a=0x1234 b=0x0FCD, accept at T -> res_valid at T+5, res_sum=0x2201, res_cout=0, res_id=0.
REQ-028 req1 a=0xFFFF b=0x0001 -> res_sum=0x0000, res_cout=1, res_id=1.
REQ-029 Both valid held from reset over three operations -> grant order req0, req1, req0; each ready pulse one cycle wide.
REQ-030 res_ready low 3 cycles in DONE -> res_valid and result held, req*_ready low, busy high; res_ready high -> IDLE next cycle.
REQ-031 rst pulsed in second ADD cycle -> next cycle res_valid=0, busy=0, pointer=req0; re-presented request completes correctly.
REQ-032 KS_SEQ_SUB_EN defined, sub=1, a=0x0005 b=0x0007 -> res_sum=0xFFFE, res_cout=0; a=0x0007 b=0x0005 -> 0x0002, res_cout=1.
